recovery_sequencer: RTL and testbench

Controller that sequences the clock-recovery event path. It latches the recovery mode, holds recovery disabled while the event path settles after enable or a mode change, and qualifies lock by counting clean recovered edges. In lock it watches for clock loss or pause and counts differential violations. It sits between software/config registers and the event selection stage: it drives that stage's `recovery_en_i`/`recovery_mode_i` and consumes its `recovered_events_o`.

---
 rtl/recovery_sequencer_if.sv | 33 +++
 rtl/recovery_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_recovery_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/recovery_sequencer_if.sv
// Config/event bundle between software registers, the recovery sequencer and event selection.
// recovered_events_i bits: [2] any_valid_edge, [1] diff_rising_edge_violation, [0] diff_falling_edge_violation.
interface recovery_sequencer_if #(
  parameter int VIOLATION_LIMIT = 4
);
  localparam int VCW = $clog2(VIOLATION_LIMIT + 1);

  logic           enable_i;
  logic [2:0]     mode_req_i;
  logic           mode_update_i;
  logic           fault_clear_i;
  logic [2:0]     recovered_events_i;
  logic           recovery_en_o;
  logic [2:0]     recovery_mode_o;
  logic           locked_o;
  logic           paused_o;
  logic           fault_o;
  logic [1:0]     fault_cause_o;
  logic [2:0]     state_o;
  logic [VCW-1:0] violation_count_o;

  modport master (
    output enable_i, mode_req_i, mode_update_i, fault_clear_i, recovered_events_i,
    input  recovery_en_o, recovery_mode_o, locked_o, paused_o, fault_o,
           fault_cause_o, state_o, violation_count_o
  );

  modport slave (
    input  enable_i, mode_req_i, mode_update_i, fault_clear_i, recovered_events_i,
    output recovery_en_o, recovery_mode_o, locked_o, paused_o, fault_o,
           fault_cause_o, state_o, violation_count_o
  );
endinterface

// File: rtl/recovery_sequencer.sv
// Sequences clock recovery: arm delay, lock qualification on clean edges, loss/pause/violation supervision.
// Every output registered, 1 cycle after the triggering input; no backpressure, inputs sampled each cycle.
module recovery_sequencer #(
  parameter int ARM_CYCLES      = 4,
  parameter int LOCK_EDGES      = 8,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int VIOLATION_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  recovery_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    SINGLE_CONTINUOUS = 3'd0, SINGLE_PAUSABLE = 3'd1, DIF_CONTINUOUS = 3'd2,
    DIF_PAUSABLE      = 3'd3, QUAD_CONTINUOUS = 3'd4, QUAD_PAUSABLE  = 3'd5
  } recovery_mode_e;

  typedef struct packed {
    logic any_valid_edge;
    logic diff_rising_edge_violation;
    logic diff_falling_edge_violation;
  } recovered_events_s;

  typedef enum logic [2:0] {
    IDLE = 3'd0, ARMING = 3'd1, ACQUIRE = 3'd2, LOCKED = 3'd3, PAUSED = 3'd4, FAULT = 3'd5
  } state_e;

  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam int EW = $clog2(LOCK_EDGES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int VW = $clog2(VIOLATION_LIMIT + 1);
  localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_CYCLES - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(LOCK_EDGES - 1);
  localparam logic [EW-1:0] EDGE_FULL = EW'(LOCK_EDGES);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [VW-1:0] VIOL_FULL = VW'(VIOLATION_LIMIT);

  state_e            state_q, state_d;
  logic [AW-1:0]     arm_q, arm_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic [VW-1:0]     viol_q, viol_d;
  logic [1:0]        cause_q, cause_d;
  recovery_mode_e    mode_q, mode_d;
  logic              en_q, locked_q, paused_q, fault_q;
  recovered_events_s ev;
  logic              viol, clean_edge, pausable, idle_exp, enter_arm;

  assign ev         = bus.recovered_events_i;
  assign viol       = ev.diff_rising_edge_violation | ev.diff_falling_edge_violation;
  assign clean_edge = ev.any_valid_edge & ~viol;
  assign pausable   = (mode_q == SINGLE_PAUSABLE) || (mode_q == DIF_PAUSABLE) ||
                      (mode_q == QUAD_PAUSABLE);

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    edge_d    = edge_q;
    idle_d    = idle_q;
    viol_d    = viol_q;
    cause_d   = cause_q;
    mode_d    = mode_q;
    idle_exp  = 1'b0;
    enter_arm = 1'b0;

    // Idle timer; any valid edge (even a violating one) proves the clock is alive.
    if (state_q == ACQUIRE || state_q == LOCKED) begin
      if (ev.any_valid_edge) begin
        idle_d = '0;
      end else if (idle_q == IDLE_LAST) begin
        idle_exp = 1'b1;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end

    if (!bus.enable_i) begin
      state_d = IDLE;
    end else if (bus.mode_update_i) begin
      mode_d    = recovery_mode_e'(bus.mode_req_i);
      enter_arm = 1'b1;
    end else if (bus.fault_clear_i && state_q == FAULT) begin
      enter_arm = 1'b1;
    end else begin
      case (state_q)
        IDLE:   enter_arm = 1'b1;
        ARMING: begin
          if (arm_q == ARM_LAST) state_d = ACQUIRE;
          else                   arm_d   = arm_q + AW'(1);
        end
        ACQUIRE: begin
          if (viol || idle_exp) begin
            edge_d = '0;
          end else if (clean_edge) begin
            if (edge_q == EDGE_LAST) begin
              edge_d  = EDGE_FULL;
              state_d = LOCKED;
            end else begin
              edge_d = edge_q + EW'(1);
            end
          end
        end
        LOCKED: begin
          if (viol && viol_q != VIOL_FULL) viol_d = viol_q + VW'(1);
          // Violation limit outranks a simultaneous timer expiry.
          if (viol && viol_d == VIOL_FULL) begin
            state_d = FAULT;
            cause_d = 2'd2;
          end else if (idle_exp) begin
            if (pausable) begin
              state_d = PAUSED;
            end else begin
              state_d = FAULT;
              cause_d = 2'd1;
            end
          end
        end
        PAUSED: begin
          if (viol) begin
            state_d = ACQUIRE;
            edge_d  = '0;
            idle_d  = '0;
          end else if (clean_edge) begin
            state_d = LOCKED;
            idle_d  = '0;
          end
        end
        FAULT:   ;
        default: state_d = IDLE;
      endcase
    end

    if (enter_arm) begin
      state_d = ARMING;
      arm_d   = '0;
      edge_d  = '0;
      idle_d  = '0;
      viol_d  = '0;
      cause_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      arm_q    <= '0;
      edge_q   <= '0;
      idle_q   <= '0;
      viol_q   <= '0;
      cause_q  <= 2'd0;
      mode_q   <= SINGLE_CONTINUOUS;
      en_q     <= 1'b0;
      locked_q <= 1'b0;
      paused_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      arm_q    <= arm_d;
      edge_q   <= edge_d;
      idle_q   <= idle_d;
      viol_q   <= viol_d;
      cause_q  <= cause_d;
      mode_q   <= mode_d;
      en_q     <= (state_d == ACQUIRE) || (state_d == LOCKED) || (state_d == PAUSED);
      locked_q <= (state_d == LOCKED);
      paused_q <= (state_d == PAUSED);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign bus.recovery_en_o     = en_q;
  assign bus.recovery_mode_o   = mode_q;
  assign bus.locked_o          = locked_q;
  assign bus.paused_o          = paused_q;
  assign bus.fault_o           = fault_q;
  assign bus.fault_cause_o     = cause_q;
  assign bus.state_o           = state_q;
  assign bus.violation_count_o = viol_q;
endmodule

// File: tb/tb_recovery_sequencer.sv
// Directed test-plan scenarios plus randomized traffic, each cycle checked against a behavioural model.
module tb_recovery_sequencer;
  localparam int ARM = 4, LOCK = 3, TMO = 8, VLIM = 2;
  localparam logic [2:0] SINGLE_CONTINUOUS = 3'd0, SINGLE_PAUSABLE = 3'd1, DIF_CONTINUOUS = 3'd2,
                         DIF_PAUSABLE = 3'd3, QUAD_PAUSABLE = 3'd5;
  localparam int S_IDLE = 0, S_ARM = 1, S_ACQ = 2, S_LCK = 3, S_PSD = 4, S_FLT = 5;

  logic clk, rst;
  logic ave, rv, fv;
  int checks = 0, errors = 0, cyc = 0;
  int m_state, m_arm, m_clean, m_quiet, m_viol, m_cause;
  logic [2:0] m_mode;
  int dens_tbl[4] = '{0, 15, 60, 100};

  recovery_sequencer_if #(.VIOLATION_LIMIT(VLIM)) bus ();

  recovery_sequencer #(
    .ARM_CYCLES(ARM), .LOCK_EDGES(LOCK), .TIMEOUT_CYCLES(TMO), .VIOLATION_LIMIT(VLIM)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = S_IDLE; m_arm = 0; m_clean = 0; m_quiet = 0;
    m_viol = 0; m_cause = 0; m_mode = SINGLE_CONTINUOUS;
  endtask

  // Spec rules applied once per clock; quiet counts edge-less cycles from 1.
  task automatic model_step();
    bit v, e, expire;
    int ns;
    v = rv | fv; e = ave & !v; expire = 0; ns = m_state;
    if (m_state == S_ACQ || m_state == S_LCK) begin
      if (ave) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == TMO) begin expire = 1; m_quiet = 0; end
      end
    end
    if (!bus.enable_i) ns = S_IDLE;
    else if (bus.mode_update_i || (bus.fault_clear_i && m_state == S_FLT) || m_state == S_IDLE) begin
      if (bus.mode_update_i) m_mode = bus.mode_req_i;
      ns = S_ARM; m_arm = 0; m_clean = 0; m_quiet = 0; m_viol = 0; m_cause = 0;
    end else begin
      case (m_state)
        S_ARM: begin m_arm++; if (m_arm == ARM) ns = S_ACQ; end
        S_ACQ: begin
          if (v || expire) m_clean = 0; else if (e) m_clean++;
          if (m_clean == LOCK) ns = S_LCK;
        end
        S_LCK: begin
          if (v && m_viol < VLIM) m_viol++;
          if (v && m_viol == VLIM) begin ns = S_FLT; m_cause = 2; end
          else if (expire) begin
            if (m_mode == SINGLE_PAUSABLE || m_mode == DIF_PAUSABLE || m_mode == QUAD_PAUSABLE) ns = S_PSD;
            else begin ns = S_FLT; m_cause = 1; end
          end
        end
        S_PSD: begin
          if (v) begin ns = S_ACQ; m_clean = 0; m_quiet = 0; end
          else if (e) begin ns = S_LCK; m_quiet = 0; end
        end
        default: ;
      endcase
    end
    m_state = ns;
  endtask

  function automatic logic [13:0] obs_vec();
    return {bus.state_o, bus.recovery_en_o, bus.locked_o, bus.paused_o, bus.fault_o,
            bus.fault_cause_o, bus.violation_count_o, bus.recovery_mode_o};
  endfunction

  function automatic logic [13:0] exp_vec();
    logic en;
    en = (m_state == S_ACQ) || (m_state == S_LCK) || (m_state == S_PSD);
    return {3'(m_state), en, (m_state == S_LCK), (m_state == S_PSD), (m_state == S_FLT),
            2'(m_cause), 2'(m_viol), m_mode};
  endfunction

  task automatic tick();
    bus.recovered_events_i = {ave, rv, fv};
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    checks++;
    assert (obs_vec() === exp_vec()) else begin
      errors++;
      $error("FAIL model cyc=%0d observed=%h expected=%h", cyc, obs_vec(), exp_vec());
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // From LOCKED (or anywhere enabled): mode update, arm, three edges, lock.
  task automatic lock_with(input logic [2:0] m, input string tag);
    bus.mode_req_i = m; bus.mode_update_i = 1'b1; ave = 1'b1; rv = 1'b0; fv = 1'b0;
    tick();
    bus.mode_update_i = 1'b0;
    chk({tag, "_arming"}, 8'(bus.state_o), 8'd1);
    chk({tag, "_mode"}, 8'(bus.recovery_mode_o), 8'(m));
    repeat (6) tick();
    chk({tag, "_acq"}, 8'(bus.state_o), 8'd2);
    tick();
    chk({tag, "_locked"}, 8'(bus.locked_o), 8'd1);
  endtask

  initial begin
    rst = 1'b1; ave = 1'b0; rv = 1'b0; fv = 1'b0;
    bus.enable_i = 1'b0; bus.mode_req_i = SINGLE_CONTINUOUS;
    bus.mode_update_i = 1'b0; bus.fault_clear_i = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_state", 8'(bus.state_o), 8'd0);
    chk("rst_en", 8'(bus.recovery_en_o), 8'd0);
    chk("rst_mode", 8'(bus.recovery_mode_o), 8'(SINGLE_CONTINUOUS));
    rst = 1'b0;

    // Scenario 1: enable at cycle 0, edge every cycle.
    bus.enable_i = 1'b1; ave = 1'b1;
    tick(); chk("s1_c1_state", 8'(bus.state_o), 8'd1);
    repeat (3) tick(); chk("s1_c4_en", 8'(bus.recovery_en_o), 8'd0);
    tick(); chk("s1_c5_state", 8'(bus.state_o), 8'd2);
    chk("s1_c5_en", 8'(bus.recovery_en_o), 8'd1);
    repeat (2) tick(); chk("s1_c7_locked", 8'(bus.locked_o), 8'd0);
    tick(); chk("s1_c8_state", 8'(bus.state_o), 8'd3);
    chk("s1_c8_locked", 8'(bus.locked_o), 8'd1);

    // Scenario 2: pausable mode, edges stop, then one edge.
    lock_with(DIF_PAUSABLE, "s2");
    tick(); ave = 1'b0;
    repeat (7) tick(); chk("s2_not_paused_yet", 8'(bus.paused_o), 8'd0);
    tick(); chk("s2_paused", 8'(bus.paused_o), 8'd1);
    chk("s2_en_in_pause", 8'(bus.recovery_en_o), 8'd1);
    ave = 1'b1;
    tick(); chk("s2_relock", 8'(bus.locked_o), 8'd1);

    // Scenario 3: continuous mode loss, then fault clear.
    lock_with(DIF_CONTINUOUS, "s3");
    tick(); ave = 1'b0;
    repeat (7) tick(); chk("s3_no_fault_yet", 8'(bus.fault_o), 8'd0);
    tick(); chk("s3_fault", 8'(bus.fault_o), 8'd1);
    chk("s3_cause", 8'(bus.fault_cause_o), 8'd1);
    chk("s3_en", 8'(bus.recovery_en_o), 8'd0);
    bus.fault_clear_i = 1'b1;
    tick(); bus.fault_clear_i = 1'b0;
    chk("s3_clear_state", 8'(bus.state_o), 8'd1);
    chk("s3_clear_cause", 8'(bus.fault_cause_o), 8'd0);

    // Scenario 4: two falling-edge violations five cycles apart in LOCKED.
    ave = 1'b1;
    repeat (7) tick(); chk("s4_locked", 8'(bus.state_o), 8'd3);
    fv = 1'b1; tick(); fv = 1'b0;
    chk("s4_vcnt1", 8'(bus.violation_count_o), 8'd1);
    repeat (4) tick(); chk("s4_still_locked", 8'(bus.state_o), 8'd3);
    fv = 1'b1; tick(); fv = 1'b0;
    chk("s4_vcnt2", 8'(bus.violation_count_o), 8'd2);
    chk("s4_fault", 8'(bus.state_o), 8'd5);
    chk("s4_cause", 8'(bus.fault_cause_o), 8'd2);

    // Scenario 5: a violation restarts the clean-edge count.
    bus.fault_clear_i = 1'b1; ave = 1'b0;
    tick(); bus.fault_clear_i = 1'b0;
    repeat (4) tick(); chk("s5_acq", 8'(bus.state_o), 8'd2);
    ave = 1'b1; repeat (2) tick();
    ave = 1'b0; rv = 1'b1; tick(); rv = 1'b0;
    chk("s5_after_viol", 8'(bus.state_o), 8'd2);
    ave = 1'b1; repeat (2) tick(); chk("s5_two_more", 8'(bus.state_o), 8'd2);
    tick(); chk("s5_locked", 8'(bus.state_o), 8'd3);

    // Scenario 6: mode update racing a disable, then a plain mode update.
    bus.enable_i = 1'b0; bus.mode_update_i = 1'b1; bus.mode_req_i = QUAD_PAUSABLE;
    tick(); bus.mode_update_i = 1'b0;
    chk("s6_idle", 8'(bus.state_o), 8'd0);
    chk("s6_mode_kept", 8'(bus.recovery_mode_o), 8'(DIF_CONTINUOUS));
    bus.enable_i = 1'b1;
    repeat (8) tick(); chk("s6_relocked", 8'(bus.state_o), 8'd3);
    rv = 1'b1; tick(); rv = 1'b0;
    chk("s6_vcnt1", 8'(bus.violation_count_o), 8'd1);
    bus.mode_update_i = 1'b1;
    tick(); bus.mode_update_i = 1'b0;
    chk("s6_arming", 8'(bus.state_o), 8'd1);
    chk("s6_mode_new", 8'(bus.recovery_mode_o), 8'(QUAD_PAUSABLE));
    chk("s6_vcnt0", 8'(bus.violation_count_o), 8'd0);
    chk("s6_en_off", 8'(bus.recovery_en_o), 8'd0);

    // Reset in LOCKED clears everything on the next edge.
    repeat (7) tick(); chk("rst_mid_locked", 8'(bus.locked_o), 8'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_state", 8'(bus.state_o), 8'd0);
    chk("rst_mid_mode", 8'(bus.recovery_mode_o), 8'(SINGLE_CONTINUOUS));
    chk("rst_mid_locked_low", 8'(bus.locked_o), 8'd0);

    // Randomized segments with varying edge density.
    for (int seg = 0; seg < 40; seg++) begin
      int dens;
      dens = dens_tbl[$urandom_range(0, 3)];
      for (int c = 0; c < 60; c++) begin
        bus.enable_i      = ($urandom_range(0, 99) < 98);
        bus.mode_update_i = ($urandom_range(0, 99) < 2);
        bus.mode_req_i    = 3'($urandom_range(0, 5));
        bus.fault_clear_i = ($urandom_range(0, 99) < 4);
        ave = ($urandom_range(0, 99) < dens);
        rv  = ($urandom_range(0, 99) < 3);
        fv  = ($urandom_range(0, 99) < 3);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
